mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, sets the BUSY cycles without s_ack_i before a transaction is aborted (legal range 2..255).
REQ-002 clk  input  1  single core clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 m0_req_i / m0_we_i  input  1/1  core data-port request; write when we=1, read when we=0.
REQ-005 m0_addr_i / m0_wdata_i / m0_sel_i  input  32/32/4  core address, write data, byte enables.
REQ-006 m0_rdata_o / m0_done_o / m0_err_o  output  32/1/1  core read data, completion pulse, error pulse.
REQ-007 m0_hold_o  output  1  stall to pipeline control; high while m0 request is outstanding.
REQ-008 m1_req_i / m1_we_i / m1_addr_i / m1_wdata_i / m1_sel_i  input  1/1/32/32/4  loader/debug requester, same meaning as m0.
REQ-009 m1_rdata_o / m1_done_o / m1_err_o  output  32/1/1  as m0.
REQ-010 s_req_o / s_we_o / s_addr_o / s_wdata_o / s_sel_o  output  1/1/32/32/4  shared data-memory port.
REQ-011 s_ack_i / s_rdata_i  input  1/32  memory acknowledge and read data, valid in the same cycle.

Function
REQ-012 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-013 IDLE: if any m*_req_i high, SHALL latch the winner's we/addr/wdata/sel and owner ID, go BUSY; else stay IDLE.
REQ-014 BUSY: s_req_o=1 with latched fields held stable; s_ack_i=1 -> latch s_rdata_i (reads only; writes latch 0), go RESP.
REQ-015 RESP: exactly one cycle; owner's done_o=1 and rdata_o=latched data; then IDLE.
REQ-016 Timeout: BUSY cycle counter reaching TIMEOUT_CYC without ack -> go RESP with owner's err_o=1, done_o=1, rdata_o=0.
REQ-017 Requesters SHALL hold req and fields stable until their done_o; the arbiter latches at grant and ignores later changes.
REQ-018 Minimum transaction latency: 3 cycles from req to done (grant, BUSY with ack, RESP).
REQ-019 m0_hold_o = m0_req_i AND NOT m0_done_o (combinational).
REQ-020 rdata_o of the non-owner SHALL be 0; done_o/err_o never high for both masters in the same cycle.
REQ-021 s_ack_i outside BUSY SHALL be ignored; outside BUSY s_req_o=0 and s_we_o/s_addr_o/s_wdata_o/s_sel_o=0.
REQ-022 Ack arriving in the same cycle the counter hits TIMEOUT_CYC SHALL win (normal completion, no error).

Reset
REQ-023 rst SHALL asynchronously force IDLE, counter 0, all outputs 0 (m0_hold_o follows m0_req_i per REQ-019).
REQ-024 Reset mid-BUSY SHALL abort silently: no done/err pulse, s_req_o drops immediately.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant to the master not granted last (last-grant flag resets to m1, so m0 wins first).
REQ-026 Macro undefined: fixed priority, m0 always wins simultaneous requests; last-grant flag not implemented.

Structure
REQ-027 Shared package holds state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), owner IDs (M0=1'b0, M1=1'b1) and TIMEOUT_CYC default.
REQ-028 One sub-module natural: arb_timeout_cnt (clear/enable/expired) for the BUSY counter; FSM and muxing stay in top.

Verification
REQ-029 m0 read addr 0x0000_0010, ack in 1st BUSY cycle with rdata 0xDEAD_BEEF -> m0_done_o on cycle 3, m0_rdata_o=0xDEAD_BEEF, m0_hold_o high cycles 1-2.
REQ-030 m1 write addr 0x100, data 0x1234_5678, sel 4'b0011 -> s_* carry exact fields while s_req_o=1; m1_done_o one pulse, m1_rdata_o=0.
REQ-031 m0 and m1 request together twice back-to-back -> with macro grants m0,m1; without macro m0,m0 (m1 served only after m0 drops req).
REQ-032 No ack, TIMEOUT_CYC=4 -> s_req_o high exactly 4 cycles, then m0_err_o=m0_done_o=1 for one cycle, rdata 0; ack at 4th cycle -> no error.
REQ-033 Assert rst during BUSY -> s_req_o=0 same cycle, no done/err pulse, next request after release served normally.
REQ-034 Stray s_ack_i in IDLE/RESP and m0 field change during BUSY -> no effect on outputs or latched fields.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encoding, owner IDs and timeout default for the arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_t;

    localparam int unsigned TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundle of both requester ports and the shared memory port.
// The slave modport is the arbiter's view (it serves the requesters and drives memory),
// the master modport is the surrounding system's view.
interface mem_bus_arbiter_if;

    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_rdata_o;
    logic        m0_done_o;
    logic        m0_err_o;
    logic        m0_hold_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_rdata_o;
    logic        m1_done_o;
    logic        m1_err_o;

    logic        s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [31:0] s_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_sel_i,
        output m0_rdata_o, m0_done_o, m0_err_o, m0_hold_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_sel_i,
        output m1_rdata_o, m1_done_o, m1_err_o,
        output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
        input  s_ack_i, s_rdata_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_sel_i,
        input  m0_rdata_o, m0_done_o, m0_err_o, m0_hold_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_sel_i,
        input  m1_rdata_o, m1_done_o, m1_err_o,
        input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
        output s_ack_i, s_rdata_i
    );

endinterface

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// arb_timeout_cnt: counts BUSY cycles; expired_o flags the last allowed cycle without ack
module arb_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Hold at zero outside BUSY, count one per BUSY cycle.
    always_comb begin
        cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    // Counter starts at 0 in the first BUSY cycle, so LIMIT-1 marks the LIMIT-th cycle.
    assign expired_o = en_i && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester arbiter onto one data-memory port with ack timeout.
// Define ARB_ROUND_ROBIN_EN for alternating grants on simultaneous requests;
// otherwise m0 has fixed priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    mem_bus_arbiter_if.slave bus
);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    owner_t      win;
    logic        any_req;
    logic        expired;
    logic        busy;
    logic        resp;

    assign any_req = bus.m0_req_i || bus.m1_req_i;
    assign busy    = state_q == BUSY;
    assign resp    = state_q == RESP;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_q, last_d;

    assign win    = owner_t'(bus.m1_req_i && (!bus.m0_req_i || last_q == M0));
    assign last_d = (state_q == IDLE && any_req) ? win : last_q;

    // Remember the latest grant so simultaneous requests alternate; m1 at reset so m0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= M1;
        else     last_q <= last_d;
    end
`else
    assign win = owner_t'(bus.m1_req_i && !bus.m0_req_i);
`endif

    arb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!busy),
        .en_i      (busy),
        .expired_o (expired)
    );

    // Next state: latch the winner at grant, finish on ack (ack beats timeout), one RESP cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    owner_d = win;
                    we_d    = win == M1 ? bus.m1_we_i    : bus.m0_we_i;
                    addr_d  = win == M1 ? bus.m1_addr_i  : bus.m0_addr_i;
                    wdata_d = win == M1 ? bus.m1_wdata_i : bus.m0_wdata_i;
                    sel_d   = win == M1 ? bus.m1_sel_i   : bus.m0_sel_i;
                end
            end
            BUSY: begin
                if (bus.s_ack_i) begin
                    state_d = RESP;
                    rdata_d = we_q ? 32'd0 : bus.s_rdata_i;
                    err_d   = 1'b0;
                end else if (expired) begin
                    state_d = RESP;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= M0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_req_o   = busy;
    assign bus.s_we_o    = busy && we_q;
    assign bus.s_addr_o  = busy ? addr_q  : 32'd0;
    assign bus.s_wdata_o = busy ? wdata_q : 32'd0;
    assign bus.s_sel_o   = busy ? sel_q   : 4'd0;

    assign bus.m0_done_o  = resp && owner_q == M0;
    assign bus.m0_err_o   = bus.m0_done_o && err_q;
    assign bus.m0_rdata_o = bus.m0_done_o ? rdata_q : 32'd0;
    assign bus.m0_hold_o  = bus.m0_req_i && !bus.m0_done_o;

    assign bus.m1_done_o  = resp && owner_q == M1;
    assign bus.m1_err_o   = bus.m1_done_o && err_q;
    assign bus.m1_rdata_o = bus.m1_done_o ? rdata_q : 32'd0;

endmodule
